// File: rtl/mips_data_mem_responder_pkg.sv
// Shared constants for the CPU data-port responder: default bases, MMIO offsets
// and STATUS bit positions.
package mips_mem_pkg;

  localparam logic [31:0] RAM_BASE_DEF  = 32'h0000_1000;
  localparam logic [31:0] MMIO_BASE_DEF = 32'h4000_0000;

  localparam logic [3:0] OFS_CYCLE  = 4'h0;
  localparam logic [3:0] OFS_TX     = 4'h4;
  localparam logic [3:0] OFS_STATUS = 4'h8;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  function automatic logic [31:0] status_word(input logic [7:0] level, input logic ovf,
                                              input logic full, input logic empty);
    logic [31:0] w;
    w = {16'h0, level, 8'h0};
    w[ST_OVF]   = ovf;
    w[ST_FULL]  = full;
    w[ST_EMPTY] = empty;
    return w;
  endfunction

endpackage

// File: rtl/mips_data_mem_responder_if.sv
// Harvard data-port bus plus the tx stream toward the external consumer.
interface mips_data_mem_responder_if;

  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;

  modport master (
    output data_address, data_read, data_write, data_writedata, tx_ready,
    input  data_readdata, tx_valid, tx_data
  );

  modport slave (
    input  data_address, data_read, data_write, data_writedata, tx_ready,
    output data_readdata, tx_valid, tx_data
  );

endinterface

// File: rtl/mips_data_mem_responder_sync_fifo.sv
// Single-clock FIFO; callers pre-gate push/pop with their clock enable.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign level_o = level_q;
  assign head_o  = mem_q[rd_q];

  // A push into a full FIFO is only accepted when a pop frees the slot this cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok)
      level_d = level_q + (AW+1)'(1);
    else if (pop_ok && !push_ok)
      level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/mips_data_mem_responder.sv
// Data-port responder: word RAM, cycle counter and tx FIFO behind a 16-byte MMIO
// window. Reads are combinational; writes commit on the enabled posedge.
module mips_data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] RAM_BASE   = RAM_BASE_DEF,
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_enable,
  mips_data_mem_responder_if.slave bus
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int FAW = $clog2(FIFO_DEPTH);

  logic [31:0]     word_addr, ram_off, mmio_off;
  logic            ram_hit, mmio_hit;
  logic [RAW-1:0]  ram_idx;
  logic [3:0]      mmio_ofs;
  logic [31:0]     ram_q [RAM_WORDS];
  logic [31:0]     cycle_q, cycle_d;
  logic            ovf_q, ovf_d;
  logic            wr_en, push, pop, w1c, ram_we;
  logic            fifo_full, fifo_empty;
  logic [FAW:0]    fifo_level;
  logic [8:0]      level_ext;
  logic [31:0]     fifo_head, status;
  logic            unused_bits;

  assign word_addr = {bus.data_address[31:2], 2'b00};
  assign ram_off   = word_addr - RAM_BASE;
  assign mmio_off  = word_addr - MMIO_BASE;
  assign ram_hit   = (word_addr >= RAM_BASE) && (ram_off < 32'(4 * RAM_WORDS));
  assign mmio_hit  = (word_addr >= MMIO_BASE) && (mmio_off < 32'd16);
  assign ram_idx   = ram_off[RAW+1:2];
  assign mmio_ofs  = {mmio_off[3:2], 2'b00};

  assign wr_en  = clk_enable && bus.data_write;
  assign ram_we = wr_en && ram_hit;
  assign push   = wr_en && mmio_hit && (mmio_ofs == OFS_TX);
  assign w1c    = wr_en && mmio_hit && (mmio_ofs == OFS_STATUS) && bus.data_writedata[ST_OVF];
  assign pop    = clk_enable && bus.tx_valid && bus.tx_ready;

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (bus.data_writedata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level),
    .head_o  (fifo_head)
  );

  // Head is masked while empty so tx_data reads 0 out of reset.
  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_empty ? 32'h0 : fifo_head;

  assign level_ext = 9'(fifo_level);
  assign status    = status_word(level_ext[7:0], ovf_q, fifo_full, fifo_empty);

  always_comb begin
    bus.data_readdata = 32'h0;
    if (bus.data_read) begin
      if (ram_hit)
        bus.data_readdata = ram_q[ram_idx];
      else if (mmio_hit) begin
        case (mmio_ofs)
          OFS_CYCLE:  bus.data_readdata = cycle_q;
          OFS_STATUS: bus.data_readdata = status;
          default:    bus.data_readdata = 32'h0;
        endcase
      end
    end
  end

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (wr_en && mmio_hit && (mmio_ofs == OFS_CYCLE))
      cycle_d = bus.data_writedata;
    ovf_d = ovf_q;
    if (push && fifo_full && !pop)
      ovf_d = 1'b1;
    else if (w1c)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clk_enable) begin
      cycle_q <= cycle_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= bus.data_writedata;
  end

  assign unused_bits = ^{bus.data_address[1:0], ram_off[31:RAW+2], ram_off[1:0],
                         mmio_off[31:4], mmio_off[1:0], level_ext[8]};

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Self-checking bench: vector table for decode/RAM, scripted sequences for
// the counter, FIFO ordering and reset corner cases.
module tb_mips_data_mem_responder;

  localparam logic [31:0] MMIO = 32'h4000_0000;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic reset, clk_enable;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] sb [$];
  vec_t vecs [17];

  mips_data_mem_responder_if bus();

  mips_data_mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.data_address = a;
    bus.data_read    = 1'b1;
    bus.data_write   = 1'b0;
    #1;
    chk(name, bus.data_readdata, exp);
    bus.data_read = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.data_address   = a;
    bus.data_writedata = d;
    bus.data_write     = 1'b1;
    bus.data_read      = 1'b0;
    tick(1);
    bus.data_write = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget = 40;
    bus.tx_ready = 1'b1;
    while (sb.size() > 0 && budget > 0) begin
      if (bus.tx_valid) chk(name, bus.tx_data, sb.pop_front());
      budget--;
      tick(1);
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d words left expected 0", name, sb.size());
      sb.delete();
    end
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, "ram_wr"};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, "ram_rd"};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_1006, 32'h0,         32'hDEAD_BEEF, "ram_rd_unaligned"};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0800, 32'h1234_5678, 32'h0, "unmapped_wr"};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0800, 32'h0,         32'h0, "unmapped_rd"};
    vecs[5]  = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,         32'h0, "no_strobe"};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_1008, 32'hAAAA_0000, 32'h0, "ram_wr2"};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_1008, 32'h5555_0000, 32'hAAAA_0000, "rw_same_prewrite"};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_1008, 32'h0,         32'h5555_0000, "rw_after"};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_1FFC, 32'hCAFE_F00D, 32'h0, "ram_top_wr"};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_1FFC, 32'h0,         32'hCAFE_F00D, "ram_top_rd"};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_2000, 32'h0000_0001, 32'h0, "ram_past_end"};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0,         32'h0, "below_ram"};
    vecs[13] = '{1'b0, 1'b1, MMIO + 32'h4,  32'h0,         32'h0, "tx_reads_zero"};
    vecs[14] = '{1'b0, 1'b1, MMIO + 32'hC,  32'h0,         32'h0, "reserved"};
    vecs[15] = '{1'b0, 1'b1, MMIO + 32'h10, 32'h0,         32'h0, "mmio_past_end"};
    vecs[16] = '{1'b0, 1'b1, MMIO + 32'h8,  32'h0,         32'h0000_0001, "status_idle"};

    reset = 1'b1;
    clk_enable = 1'b1;
    bus.data_address = '0;
    bus.data_read = 1'b0;
    bus.data_write = 1'b0;
    bus.data_writedata = '0;
    bus.tx_ready = 1'b0;
    tick(3);
    chk("reset_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    chk("reset_tx_data", bus.tx_data, 32'h0);
    rd_chk("reset_cycle", MMIO, 32'h0);
    reset = 1'b0;

    // cycle counter
    tick(10);
    rd_chk("cycle_10", MMIO, 32'd10);
    wr(MMIO, 32'hFFFF_FFFF);
    rd_chk("cycle_loaded", MMIO, 32'hFFFF_FFFF);
    tick(1);
    rd_chk("cycle_wrap", MMIO, 32'h0);
    clk_enable = 1'b0;
    tick(5);
    rd_chk("cycle_frozen", MMIO, 32'h0);
    clk_enable = 1'b1;

    // decode / RAM table
    for (int i = 0; i < 17; i++) begin
      bus.data_write     = vecs[i].wr;
      bus.data_read      = vecs[i].rd;
      bus.data_address   = vecs[i].addr;
      bus.data_writedata = vecs[i].wdata;
      #1;
      chk(vecs[i].name, bus.data_readdata, vecs[i].exp);
      tick(1);
    end
    bus.data_write = 1'b0;
    bus.data_read  = 1'b0;

    // FIFO fill, overflow, ordered drain, W1C
    for (int i = 1; i <= 8; i++) begin
      wr(MMIO + 32'h4, 32'(i));
      sb.push_back(32'(i));
    end
    rd_chk("status_full", MMIO + 32'h8, 32'h0000_0802);
    chk("tx_head", bus.tx_data, 32'd1);
    tick(2);
    chk("tx_head_stable", bus.tx_data, 32'd1);
    chk("tx_valid_hold", {31'b0, bus.tx_valid}, 32'h1);
    wr(MMIO + 32'h4, 32'd9);
    rd_chk("status_overflow", MMIO + 32'h8, 32'h0000_0806);
    drain("drain_order");
    rd_chk("status_drained", MMIO + 32'h8, 32'h0000_0005);
    wr(MMIO + 32'h8, 32'h4);
    rd_chk("status_w1c", MMIO + 32'h8, 32'h0000_0001);

    // push into full FIFO while popping
    for (int i = 0; i < 8; i++) begin
      wr(MMIO + 32'h4, 32'h100 + 32'(i));
      sb.push_back(32'h100 + 32'(i));
    end
    bus.data_address   = MMIO + 32'h4;
    bus.data_writedata = 32'hA5;
    bus.data_write     = 1'b1;
    bus.tx_ready       = 1'b1;
    #1;
    chk("pushpop_head", bus.tx_data, sb.pop_front());
    sb.push_back(32'hA5);
    tick(1);
    bus.data_write = 1'b0;
    bus.tx_ready   = 1'b0;
    rd_chk("status_pushpop", MMIO + 32'h8, 32'h0000_0802);
    drain("drain_pushpop");

    // reset while holding entries and disabled
    for (int i = 0; i < 3; i++) wr(MMIO + 32'h4, 32'h200 + 32'(i));
    clk_enable = 1'b0;
    reset = 1'b1;
    tick(1);
    chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    chk("rst_tx_data", bus.tx_data, 32'h0);
    rd_chk("rst_status", MMIO + 32'h8, 32'h0000_0001);
    rd_chk("rst_cycle", MMIO, 32'h0);
    rd_chk("rst_ram_kept", 32'h0000_1004, 32'hDEAD_BEEF);
    reset = 1'b0;
    clk_enable = 1'b1;
    tick(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
